// File: rtl/output_port_scheduler_if.sv
// Command handshake bundle for the output port scheduler.
// The master offers timestamped commands; the slave (scheduler) accepts them.
interface output_port_scheduler_if #(
    parameter int NUM_DATA   = 1,
    parameter int DEST_WIDTH = 4,
    parameter int TIME_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [TIME_WIDTH-1:0] cmd_time;
    logic [DEST_WIDTH-1:0] cmd_dest;
    logic [NUM_DATA-1:0]   cmd_data;

    modport master (
        output cmd_valid,
        output cmd_time,
        output cmd_dest,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_time,
        input  cmd_dest,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/output_port_scheduler.sv
// Timed output port scheduler.
// Commands {time, dest, data} are queued in order. Each cycle the queue head is
// compared against a free-running time counter: it fires when the times match,
// is dropped as late when its time has passed, and is dropped immediately when
// its destination does not exist. A fire drives a registered one-hot write
// enable and the shared write data one cycle later.
module output_port_scheduler #(
    parameter int NUM_DATA   = 1,
    parameter int NUM_PORTS  = 4,
    parameter int DEST_WIDTH = 4,
    parameter int TIME_WIDTH = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  counter_en,
    input  logic                  flush,
    input  logic                  clear_flags,
    output_port_scheduler_if.slave cmd,
    output logic [NUM_PORTS-1:0]  port_wr_en,
    output logic [NUM_DATA-1:0]   port_data,
    output logic [TIME_WIDTH-1:0] time_now,
    output logic                  busy,
    output logic                  late_flag,
    output logic                  bad_dest_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Queue storage is data-only and never reset; pointers carry validity.
    logic [TIME_WIDTH-1:0] r_mem_time [FIFO_DEPTH];
    logic [DEST_WIDTH-1:0] r_mem_dest [FIFO_DEPTH];
    logic [NUM_DATA-1:0]   r_mem_data [FIFO_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [TIME_WIDTH-1:0] r_time;
    logic [NUM_PORTS-1:0]  r_wr_en;
    logic [NUM_DATA-1:0]   r_data;
    logic                  r_late;
    logic                  r_bad;

    logic [AW:0]           w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic [TIME_WIDTH-1:0] w_head_time;
    logic [DEST_WIDTH-1:0] w_head_dest;
    logic [NUM_DATA-1:0]   w_head_data;
    logic                  w_eval;
    logic                  w_dest_bad;
    logic                  w_bad_pop;
    logic                  w_late_pop;
    logic                  w_fire;
    logic                  w_pop;
    logic [NUM_PORTS-1:0]  w_onehot;

    // Queue status, head decode and the per-cycle fire/discard decision.
    always_comb begin
        w_count     = r_wr_ptr - r_rd_ptr;
        w_empty     = (w_count == '0);
        w_full      = (w_count == (AW+1)'(FIFO_DEPTH));
        // Pushes offered while flushing are dropped along with the queue.
        w_push      = cmd.cmd_valid && !w_full && !flush;
        w_head_time = r_mem_time[r_rd_ptr[AW-1:0]];
        w_head_dest = r_mem_dest[r_rd_ptr[AW-1:0]];
        w_head_data = r_mem_data[r_rd_ptr[AW-1:0]];
        // A flush cycle suppresses any head action so nothing fires from it.
        w_eval      = !w_empty && !flush;
        // Widened compare so NUM_PORTS == 2**DEST_WIDTH is representable.
        w_dest_bad  = ({1'b0, w_head_dest} >= (DEST_WIDTH+1)'(NUM_PORTS));
        w_bad_pop   = w_eval && w_dest_bad;
        w_late_pop  = w_eval && !w_dest_bad && (w_head_time < r_time);
        w_fire      = w_eval && !w_dest_bad && (w_head_time == r_time);
        w_pop       = w_bad_pop || w_late_pop || w_fire;
        w_onehot    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_onehot[i] = ({1'b0, w_head_dest} == (DEST_WIDTH+1)'(i));
        end
    end

    // Control state: counter, queue pointers, registered port outputs, flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_time   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_wr_en  <= '0;
            r_data   <= '0;
            r_late   <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            if (counter_en) begin
                r_time <= r_time + TIME_WIDTH'(1);
            end
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                end
            end
            r_wr_en <= w_fire ? w_onehot : '0;
            if (w_fire) begin
                r_data <= w_head_data;
            end
            // A set event wins over a simultaneous clear.
            if (w_late_pop) begin
                r_late <= 1'b1;
            end else if (clear_flags) begin
                r_late <= 1'b0;
            end
            if (w_bad_pop) begin
                r_bad <= 1'b1;
            end else if (clear_flags) begin
                r_bad <= 1'b0;
            end
        end
    end

    // Queue entry write on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_time[r_wr_ptr[AW-1:0]] <= cmd.cmd_time;
            r_mem_dest[r_wr_ptr[AW-1:0]] <= cmd.cmd_dest;
            r_mem_data[r_wr_ptr[AW-1:0]] <= cmd.cmd_data;
        end
    end

    assign cmd.cmd_ready  = !w_full;
    assign port_wr_en     = r_wr_en;
    assign port_data      = r_data;
    assign time_now       = r_time;
    assign busy           = !w_empty;
    assign late_flag      = r_late;
    assign bad_dest_flag  = r_bad;

endmodule
